// File: rtl/std_fifo_pkg.sv
// ============================================================================
// Module : std_fifo_pkg
// Brief  : Shared constants and helpers for the block-RAM FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package std_fifo_pkg;

  localparam int PREFETCH_DEPTH = 2;

  function automatic int fifo_count_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/std_block_ram_double.sv
// ============================================================================
// Module : std_block_ram_double
// Brief  : Dual-port block RAM, port 0 byte-masked write, port 1 read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module std_block_ram_double #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [DATA_WIDTH/8-1:0] i_wr_mask,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (i_wr_mask[b]) r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_rd_data_q;
      always_ff @(posedge clk) r_rd_data_q <= r_rd_data;
      assign o_rd_data = r_rd_data_q;
    end else begin : g_no_out_reg
      assign o_rd_data = r_rd_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/std_fifo_prefetch.sv
// ============================================================================
// Module : std_fifo_prefetch
// Brief  : Two-entry show-ahead register buffer in front of the RAM read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module std_fifo_prefetch
  import std_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  localparam logic [1:0] c_full = 2'(PREFETCH_DEPTH);

  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_pop;

  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
    end else if (i_wr_en && !w_pop && (r_count != c_full)) begin
      r_count <= r_count + 2'd1;
    end else if (!i_wr_en && w_pop) begin
      r_count <= r_count - 2'd1;
    end
  end

  // Head always holds the oldest word; tail only fills when head is occupied.
  always_ff @(posedge clk) begin
    case ({i_wr_en, w_pop})
      2'b10: begin
        if (r_count == 2'd0) r_head <= i_wr_data;
        else                 r_tail <= i_wr_data;
      end
      2'b01: r_head <= r_tail;
      2'b11: begin
        if (r_count == 2'd1) begin
          r_head <= i_wr_data;
        end else begin
          r_head <= r_tail;
          r_tail <= i_wr_data;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/std_fifo_block_ram.sv
// ============================================================================
// Module : std_fifo_block_ram
// Brief  : Valid/ready FIFO on block RAM with a 2-word show-ahead prefetch.
//          Define STD_FIFO_BLOCK_RAM_COUNT_EN to get a registered occupancy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module std_fifo_block_ram
  import std_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [fifo_count_width(ADDR_WIDTH)-1:0] count
);

  localparam int                  c_cw       = fifo_count_width(ADDR_WIDTH);
  localparam int unsigned         c_depth    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_ram_full = c_depth[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_cnt_one  = 1;
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_count;
  logic [ADDR_WIDTH:0]   w_ram_count_nxt;
  logic                  r_pending;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [1:0]            w_pf_count;
  logic [2:0]            w_inflight;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign in_ready   = (r_ram_count != c_ram_full);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_inflight = {1'b0, w_pf_count} + {2'b00, r_pending};
  // A pop frees a prefetch slot this cycle, so the read can be issued early.
  assign w_rd_en    = (r_ram_count != '0) && ((w_inflight < 3'd2) || w_pop);

  always_comb begin
    w_ram_count_nxt = r_ram_count;
    if (w_push && !w_rd_en)      w_ram_count_nxt = r_ram_count + c_cnt_one;
    else if (!w_push && w_rd_en) w_ram_count_nxt = r_ram_count - c_cnt_one;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_ram_count <= w_ram_count_nxt;
      r_pending   <= w_rd_en;
    end
  end

  std_block_ram_double #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUT_REG    (1'b0)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_mask ({(DATA_WIDTH/8){1'b1}}),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  std_fifo_prefetch #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_pending),
    .i_wr_data (w_rd_data),
    .o_valid   (out_valid),
    .i_ready   (out_ready),
    .o_data    (out_data),
    .o_count   (w_pf_count)
  );

`ifdef STD_FIFO_BLOCK_RAM_COUNT_EN
  logic [c_cw-1:0] r_count;

  // Sum of next-state terms so count tracks the occupancy after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= c_cw'(w_ram_count_nxt) + c_cw'(w_rd_en) + c_cw'(w_pf_count)
               + c_cw'(r_pending) - c_cw'(w_pop);
    end
  end

  assign count = r_count;
`else
  assign count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_std_fifo_block_ram.sv
// ============================================================================
// Module : tb_std_fifo_block_ram
// Brief  : Randomized and directed bench for std_fifo_block_ram (DEPTH=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_std_fifo_block_ram;

`ifdef STD_FIFO_BLOCK_RAM_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif
  localparam int RAM_DEPTH = 4;
  localparam int CAPACITY  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] count;

  std_fifo_block_ram #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: words stored, read in flight, and in the show-ahead buffer.
  int         m_ram, m_fl, m_out;
  logic [7:0] sb[$];
  int         n_push, n_pops;
  logic       hold_v;
  logic [7:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
    return COUNT_EN ? n : 0;
  endfunction

  task automatic model_clear();
    m_ram = 0; m_fl = 0; m_out = 0;
    sb.delete();
    hold_v = 1'b0;
  endtask

  // One clock: compare at the negedge, drive, advance the model, step.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy);
    logic pu, po, rd;
    chk("in_ready", in_ready, (m_ram != RAM_DEPTH));
    chk("out_valid", out_valid, (m_out != 0));
    chk("count", count, exp_cnt(m_ram + m_fl + m_out));
    chk("count_max", (count <= CAPACITY), 1);
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_d);
    end
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    pu = iv && (m_ram != RAM_DEPTH);
    po = (m_out != 0) && ordy;
    if (po) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else                chk("data", out_data, sb.pop_front());
      n_pops++;
    end
    rd = (m_ram > 0) && (((m_out + m_fl) < 2) || po);
    hold_v = (m_out != 0) && !ordy;
    hold_d = out_data;
    m_out = m_out - int'(po) + m_fl;
    m_fl  = int'(rd);
    m_ram = m_ram + int'(pu) - int'(rd);
    if (pu) begin
      sb.push_back(id);
      n_push++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string tag, input int n);
    int p0 = n_pops;
    for (int k = 0; k < 40; k++) begin
      if (m_ram == 0 && m_fl == 0 && m_out == 0) break;
      cycle(1'b0, 8'h00, 1'b1);
    end
    chk(tag, n_pops - p0, n);
  endtask

  initial begin
    int p0, gaps, first_idx;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_push = 0; n_pops = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);

    // Single word latency
    cycle(1'b1, 8'hA5, 1'b0);
    chk("lat_e0", out_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lat_e1", out_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lat_e2", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_count", count, exp_cnt(1));
    cycle(1'b0, 8'h00, 1'b1);
    chk("single_popped", out_valid, 0);

    // Fill to capacity
    p0 = n_push;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i + 1), 1'b0);
    chk("fill_accepted", n_push - p0, CAPACITY);
    chk("fill_ready", in_ready, 0);
    chk("fill_count", count, exp_cnt(CAPACITY));
    drain("fill_drain", CAPACITY);

    // Streaming with no bubbles
    reset_pulse();
    p0 = n_pops; gaps = 0; seen = 1'b0; first_idx = -1;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) begin
        if (!seen) first_idx = i;
        seen = 1'b1;
      end else if (seen && (n_pops - p0) < 64) begin
        gaps++;
      end
      cycle(i < 64, 8'(i), 1'b1);
    end
    chk("stream_first", first_idx, 3);
    chk("stream_gaps", gaps, 0);
    chk("stream_pops", n_pops - p0, 64);

    // Full with simultaneous pop
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(i + 1), 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    chk("full_ready", in_ready, 0);
    chk("full_head", out_data, 8'h01);
    p0 = n_push;
    cycle(1'b1, 8'hEE, 1'b1);
    chk("full_no_push", n_push - p0, 0);
    chk("full_ready_next", in_ready, 1);
    cycle(1'b1, 8'hEF, 1'b0);
    chk("full_push_next", n_push - p0, 1);
    drain("full_drain", CAPACITY);

    // Random backpressure
    p0 = n_push;
    for (int c = 0; c < 20000 && (n_push - p0) < 2000; c++) begin
      cycle(($urandom % 100) < 70, 8'($urandom), ($urandom % 100) < 30);
    end
    chk("rand_pushed", n_push - p0, 2000);
    drain("rand_drain", m_ram + m_fl + m_out);
    chk("rand_sb_empty", sb.size(), 0);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    chk("mid_count", count, exp_cnt(4));
    reset_pulse();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_count", count, 0);
    cycle(1'b1, 8'h5A, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    chk("mid_first_valid", out_valid, 1);
    chk("mid_first_data", out_data, 8'h5A);
    drain("mid_drain", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
